// File: rtl/vctr_fetch_ctrl.sv
// Vector fetch controller: pops a base address, issues BURST_LEN single-word
// reads, optionally byte-swaps the returned words and writes them to the vector FIFO.
module vctr_fetch_ctrl #(
  parameter int BURST_LEN = 8,
  parameter int ADDR_INC  = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_program,
  input  logic        end_program,
  input  logic [31:0] addr_fifo_dout,
  input  logic        addr_fifo_empty,
  output logic        addr_fifo_rd,
  input  logic [15:0] vector_fifo_threshold,
  input  logic [15:0] words_in_vctr_fifo,
  input  logic        vector_fifo_full,
  input  logic        vector_byte_swap,
  output logic [31:0] master_addr,
  output logic        master_rd,
  input  logic [31:0] master_data_in,
  input  logic        master_data_in_val,
  output logic [31:0] vctr_fifo_din,
  output logic        vctr_fifo_wr,
  output logic        fetch_busy,
  output logic        fetch_error,
  output logic [31:0] bursts_done
);

  localparam int BW = $clog2(BURST_LEN);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERROR} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   base_q, base_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   din_q, din_d;
  logic [31:0]   bursts_q, bursts_d;
  logic          wr_q, wr_d;
  logic          err_q, err_d;
  logic          pop;
  logic          start;
  logic [16:0]   need;
  logic [31:0]   swapped;
  logic [31:0]   issue_addr;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    tmo_d      = tmo_q;
    base_d     = base_q;
    din_d      = din_q;
    bursts_d   = bursts_q;
    wr_d       = 1'b0;
    err_d      = err_q;
    pop        = 1'b0;
    // 17-bit headroom sum so a nearly full FIFO can never wrap into a pass
    need       = {1'b0, words_in_vctr_fifo} + 17'(BURST_LEN);
    start      = run_program & ~end_program & ~addr_fifo_empty &
                 (need <= {1'b0, vector_fifo_threshold});
    swapped    = {master_data_in[7:0], master_data_in[15:8],
                  master_data_in[23:16], master_data_in[31:24]};
    issue_addr = base_q + (32'(beat_q) * 32'(ADDR_INC));
    addr_d     = (state_q == ISSUE) ? issue_addr : addr_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          pop     = 1'b1;
          base_d  = addr_fifo_dout;
          beat_d  = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (master_data_in_val) begin
          if (vector_fifo_full) begin
            err_d = 1'b1;
          end else begin
            wr_d  = 1'b1;
            din_d = vector_byte_swap ? swapped : master_data_in;
          end
          if (beat_q == BW'(BURST_LEN - 1)) begin
            bursts_d = bursts_q + 32'd1;
            state_d  = IDLE;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = ISSUE;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ERROR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ERROR: begin
        if (!run_program) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      tmo_q    <= '0;
      base_q   <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      bursts_q <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      tmo_q    <= tmo_d;
      base_q   <= base_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      bursts_q <= bursts_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
    end
  end

  // The pop is combinational from IDLE; mask it while reset holds the FSM
  assign addr_fifo_rd  = pop & ~reset;
  assign master_rd     = (state_q == ISSUE);
  assign master_addr   = addr_d;
  assign vctr_fifo_din = din_q;
  assign vctr_fifo_wr  = wr_q;
  assign fetch_busy    = (state_q != IDLE);
  assign fetch_error   = err_q;
  assign bursts_done   = bursts_q;

endmodule

// File: tb/tb_vctr_fetch_ctrl.sv
// Bench for vctr_fetch_ctrl: vector table of bursts plus hand-written sequences
// for gating, mid-burst events, timeout and reset; data checked via a scoreboard.
module tb_vctr_fetch_ctrl;

  localparam int BL  = 8;
  localparam int TMO = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_program, end_program;
  logic [31:0] addr_fifo_dout;
  logic        addr_fifo_empty, addr_fifo_rd;
  logic [15:0] vector_fifo_threshold, words_in_vctr_fifo;
  logic        vector_fifo_full, vector_byte_swap;
  logic [31:0] master_addr, master_data_in;
  logic        master_rd, master_data_in_val;
  logic [31:0] vctr_fifo_din, bursts_done;
  logic        vctr_fifo_wr, fetch_busy, fetch_error;

  vctr_fetch_ctrl #(.BURST_LEN(BL), .ADDR_INC(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .run_program(run_program), .end_program(end_program),
    .addr_fifo_dout(addr_fifo_dout), .addr_fifo_empty(addr_fifo_empty),
    .addr_fifo_rd(addr_fifo_rd), .vector_fifo_threshold(vector_fifo_threshold),
    .words_in_vctr_fifo(words_in_vctr_fifo), .vector_fifo_full(vector_fifo_full),
    .vector_byte_swap(vector_byte_swap), .master_addr(master_addr), .master_rd(master_rd),
    .master_data_in(master_data_in), .master_data_in_val(master_data_in_val),
    .vctr_fifo_din(vctr_fifo_din), .vctr_fifo_wr(vctr_fifo_wr), .fetch_busy(fetch_busy),
    .fetch_error(fetch_error), .bursts_done(bursts_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] base;
    logic [15:0] occ;
    logic [15:0] thr;
    logic        swap;
    logic        full;
    logic        exp_pop;
  } vec_t;

  vec_t        vecs[9];
  logic [31:0] exp_q[$];
  logic [31:0] addr_exp_q[$];
  int          total = 0, bad = 0;
  int          pop_cnt = 0, rd_cnt = 0, wr_cnt = 0, exp_bursts = 0;
  logic [31:0] last_din = '0;
  logic        mem_stall = 1'b0, fixed_en = 1'b0, stray_req = 1'b0;
  logic [31:0] fixed_data = '0;
  logic        m_rd_seen, m_stray;
  logic [31:0] m_addr;

  function automatic logic [31:0] swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return fixed_en ? fixed_data : (a ^ 32'h5A5A_C3C3);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got 0x%08h with nothing expected", name, act);
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pop(input int p0, input int limit, output bit popped);
    popped = 1'b0;
    for (int i = 0; i < limit && !popped; i++) begin
      @(negedge clk); #1;
      if (pop_cnt != p0) popped = 1'b1;
    end
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (fetch_busy && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    if (fetch_busy) fail_now("idle_wait_expired", 32'(n));
  endtask

  task automatic wait_rd(input int target, input int limit);
    int n;
    n = 0;
    while (rd_cnt < target && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    if (rd_cnt < target) fail_now("rd_wait_expired", 32'(rd_cnt));
  endtask

  task automatic start_burst(input logic [31:0] base, output bit popped);
    addr_fifo_dout  = base;
    addr_fifo_empty = 1'b0;
    wait_pop(pop_cnt, 4, popped);
    @(posedge clk); #1;
    addr_fifo_empty = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bit popped;
    int p0, w0;
    vector_fifo_full      = v.full;
    words_in_vctr_fifo    = v.occ;
    vector_fifo_threshold = v.thr;
    vector_byte_swap      = v.swap;
    addr_fifo_dout        = v.base;
    addr_fifo_empty       = 1'b0;
    p0 = pop_cnt;
    w0 = wr_cnt;
    wait_pop(p0, 4, popped);
    check({tag, "_pop"}, 32'(popped), 32'(v.exp_pop));
    @(posedge clk); #1;
    addr_fifo_empty = 1'b1;
    wait_idle(100);
    if (v.exp_pop) exp_bursts++;
    check({tag, "_bursts"}, bursts_done, 32'(exp_bursts));
    check({tag, "_writes"}, 32'(wr_cnt - w0), (v.exp_pop && !v.full) ? 32'(BL) : 32'd0);
    check({tag, "_busy"}, 32'(fetch_busy), 32'd0);
    tick(1);
    vector_fifo_full = 1'b0;
  endtask

  // memory model: answers each read one cycle later and queues the expected write
  initial begin
    master_data_in_val = 1'b0;
    master_data_in     = '0;
    forever begin
      @(negedge clk);
      m_rd_seen = master_rd & ~reset;
      m_addr    = master_addr;
      m_stray   = stray_req;
      @(posedge clk); #1;
      if (m_rd_seen && !mem_stall && !reset) begin
        master_data_in     = mem_word(m_addr);
        master_data_in_val = 1'b1;
        if (!vector_fifo_full)
          exp_q.push_back(vector_byte_swap ? swap32(mem_word(m_addr)) : mem_word(m_addr));
      end else if (m_stray) begin
        master_data_in     = 32'hBAD0_0001;
        master_data_in_val = 1'b1;
      end else begin
        master_data_in_val = 1'b0;
      end
    end
  end

  // monitor: pops, read addresses and FIFO writes
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (addr_fifo_rd) begin
          pop_cnt++;
          for (int i = 0; i < BL; i++) addr_exp_q.push_back(addr_fifo_dout + 32'(i * 4));
        end
        if (master_rd) begin
          rd_cnt++;
          if (addr_exp_q.size() == 0) fail_now("unexpected_rd", master_addr);
          else check("rd_addr", master_addr, addr_exp_q.pop_front());
        end
        if (vctr_fifo_wr) begin
          wr_cnt++;
          last_din = vctr_fifo_din;
          if (exp_q.size() == 0) fail_now("unexpected_wr", vctr_fifo_din);
          else check("wr_data", vctr_fifo_din, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   popped;
    int   p0, w0, r0, n;
    vec_t v;

    //            base           occ       thr       swap  full  pop
    vecs[0] = '{32'h0000_1000, 16'd0,    16'd64,   1'b0, 1'b0, 1'b1};
    vecs[1] = '{32'h0000_2000, 16'd57,   16'd64,   1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h0000_2000, 16'd56,   16'd64,   1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_3000, 16'd0,    16'd64,   1'b1, 1'b0, 1'b1};
    vecs[4] = '{32'h0000_4000, 16'd0,    16'd7,    1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_4000, 16'd0,    16'd8,    1'b0, 1'b0, 1'b1};
    vecs[6] = '{32'h0000_5000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'h0000_5000, 16'hFFF0, 16'hFFFF, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{32'hFFFF_FFF8, 16'd0,    16'd64,   1'b1, 1'b0, 1'b1};

    // reset with a start condition present: nothing may leak out
    reset = 1'b1; run_program = 1'b1; end_program = 1'b0;
    addr_fifo_dout = 32'h0000_0F00; addr_fifo_empty = 1'b0;
    vector_fifo_threshold = 16'd64; words_in_vctr_fifo = 16'd0;
    vector_fifo_full = 1'b0; vector_byte_swap = 1'b0;
    tick(2);
    @(negedge clk); #1;
    check("rst_flags", 32'({addr_fifo_rd, master_rd, vctr_fifo_wr, fetch_busy, fetch_error}), 32'd0);
    check("rst_buses", master_addr | vctr_fifo_din | bursts_done, 32'd0);
    addr_fifo_empty = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(2);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // occupancy drops to the limit: pop follows in that cycle
    words_in_vctr_fifo = 16'd57; addr_fifo_dout = 32'h0000_7000; addr_fifo_empty = 1'b0;
    p0 = pop_cnt;
    wait_pop(p0, 3, popped);
    check("thr_hold_pop", 32'(pop_cnt - p0), 32'd0);
    @(posedge clk); #1;
    words_in_vctr_fifo = 16'd56;
    @(negedge clk); #1;
    check("thr_release_pop", 32'(pop_cnt - p0), 32'd1);
    @(posedge clk); #1;
    addr_fifo_empty = 1'b1; words_in_vctr_fifo = 16'd0;
    wait_idle(100); exp_bursts++;
    check("thr_release_bursts", bursts_done, 32'(exp_bursts));
    tick(1);

    // explicit byte-swap constant
    fixed_en = 1'b1; fixed_data = 32'h1122_3344;
    v = '{32'h0000_8000, 16'd0, 16'd64, 1'b1, 1'b0, 1'b1};
    run_vec(v, "swap1");
    check("swap1_din", last_din, 32'h4433_2211);
    v.swap = 1'b0;
    run_vec(v, "swap0");
    check("swap0_din", last_din, 32'h1122_3344);
    fixed_en = 1'b0;

    // end_program mid-burst: burst completes, no further pops
    w0 = wr_cnt; r0 = rd_cnt;
    start_burst(32'h0000_9000, popped);
    wait_rd(r0 + 4, 50);
    @(posedge clk); #1;
    end_program = 1'b1;
    wait_idle(100); exp_bursts++;
    check("endp_writes", 32'(wr_cnt - w0), 32'(BL));
    check("endp_bursts", bursts_done, 32'(exp_bursts));
    tick(1);
    p0 = pop_cnt;
    addr_fifo_dout = 32'h0000_A000; addr_fifo_empty = 1'b0;
    tick(20);
    check("endp_no_pop", 32'(pop_cnt - p0), 32'd0);
    addr_fifo_empty = 1'b1; end_program = 1'b0;
    tick(1);
    check("no_error_yet", 32'(fetch_error), 32'd0);

    // stray valid while idle: ignored
    w0 = wr_cnt;
    stray_req = 1'b1; tick(1); stray_req = 1'b0; tick(4);
    check("stray_writes", 32'(wr_cnt - w0), 32'd0);
    check("stray_error", 32'(fetch_error), 32'd0);

    // reset mid-burst
    r0 = rd_cnt;
    start_burst(32'h0000_B000, popped);
    wait_rd(r0 + 4, 50);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_flags", 32'({addr_fifo_rd, master_rd, vctr_fifo_wr, fetch_busy, fetch_error}), 32'd0);
    check("mid_rst_buses", master_addr | vctr_fifo_din | bursts_done, 32'd0);
    exp_q.delete(); addr_exp_q.delete(); exp_bursts = 0;
    tick(3);
    reset = 1'b0;
    tick(5);
    check("mid_rst_bursts", bursts_done, 32'd0);
    check("mid_rst_sb", 32'(exp_q.size() + addr_exp_q.size()), 32'd0);

    // read timeout, ERROR hold, recovery via run_program, then reset
    mem_stall = 1'b1;
    r0 = rd_cnt;
    start_burst(32'h0000_C000, popped);
    wait_rd(r0 + 1, 10);
    n = 0;
    while (!fetch_error && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    check("timeout_cycles", 32'(n), 32'(TMO + 1));
    check("timeout_busy", 32'(fetch_busy), 32'd1);
    addr_exp_q.delete();
    mem_stall = 1'b0;
    r0 = rd_cnt; p0 = pop_cnt;
    tick(1);
    addr_fifo_dout = 32'h0000_D000; addr_fifo_empty = 1'b0;
    tick(10);
    check("err_no_rd", 32'(rd_cnt - r0), 32'd0);
    check("err_no_pop", 32'(pop_cnt - p0), 32'd0);
    addr_fifo_empty = 1'b1; run_program = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    check("err_exit_busy", 32'(fetch_busy), 32'd0);
    check("err_sticky", 32'(fetch_error), 32'd1);
    tick(1);
    run_program = 1'b1;
    reset = 1'b1; tick(2); reset = 1'b0; tick(1);
    check("err_cleared", 32'(fetch_error), 32'd0);

    // data arriving while the vector FIFO is full: dropped, error set
    v = '{32'h0000_E000, 16'd0, 16'd64, 1'b0, 1'b1, 1'b1};
    run_vec(v, "full");
    check("full_error", 32'(fetch_error), 32'd1);

    check("sb_drain", 32'(exp_q.size() + addr_exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
